// File: rtl/asip_alu.sv
// ASIP datapath ALU: 16 data-processing ops with NZCV flags.
// A status register keeps the last flags and feeds carry-in back.
module asip_alu #(
   parameter int bits = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [bits-1:0] A,
   input  logic [bits-1:0] B,
   input  logic [bits-1:0] C,
   input  logic [3:0]      Control,
   output logic [bits-1:0] Result,
   output logic [3:0]      Flags,
   output logic [3:0]      FlagsQ
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_XOR = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_RSB = 4'b0011;
   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_ADC = 4'b0101;
   localparam logic [3:0] OP_SBC = 4'b0110;
   localparam logic [3:0] OP_RSC = 4'b0111;
   localparam logic [3:0] OP_TST = 4'b1000;
   localparam logic [3:0] OP_TEQ = 4'b1001;
   localparam logic [3:0] OP_CMP = 4'b1010;
   localparam logic [3:0] OP_CMN = 4'b1011;
   localparam logic [3:0] OP_OR  = 4'b1100;
   localparam logic [3:0] OP_MOV = 4'b1101;
   localparam logic [3:0] OP_BIC = 4'b1110;
   localparam logic [3:0] OP_NOT = 4'b1111;

   logic [3:0]      flags_d;
   logic [3:0]      flags_q;
   logic [bits-1:0] add_x;
   logic [bits-1:0] add_y;
   logic            add_ci;
   logic            arith;
   logic            cin;
   logic [bits:0]   sum;
   logic [bits-1:0] res;
   logic            unused_c;

   assign unused_c = ^C[bits-1:1];

   // C[0] optionally inverts the stored carry before it enters the adder
   assign cin = flags_q[1] ^ C[0];

   always_comb begin
      add_x   = A;
      add_y   = B;
      add_ci  = 1'b0;
      arith   = 1'b0;
      res     = '0;
      flags_d = 4'b0000;
      case (Control)
         OP_AND, OP_TST: res = A & B;
         OP_XOR, OP_TEQ: res = A ^ B;
         OP_OR:          res = A | B;
         OP_MOV:         res = B;
         OP_BIC:         res = A & ~B;
         OP_NOT:         res = ~B;
         OP_SUB, OP_CMP: begin
            add_y  = ~B;
            add_ci = 1'b1;
            arith  = 1'b1;
         end
         OP_RSB: begin
            add_x  = B;
            add_y  = ~A;
            add_ci = 1'b1;
            arith  = 1'b1;
         end
         OP_ADD, OP_CMN: arith = 1'b1;
         OP_ADC: begin
            add_ci = cin;
            arith  = 1'b1;
         end
         OP_SBC: begin
            add_y  = ~B;
            add_ci = cin;
            arith  = 1'b1;
         end
         OP_RSC: begin
            add_x  = B;
            add_y  = ~A;
            add_ci = cin;
            arith  = 1'b1;
         end
         default: res = '0;
      endcase
      sum = {1'b0, add_x} + {1'b0, add_y} + {{bits{1'b0}}, add_ci};
      if (arith) begin
         res        = sum[bits-1:0];
         flags_d[1] = sum[bits];
         flags_d[0] = (add_x[bits-1] == add_y[bits-1]) &&
                      (sum[bits-1] != add_x[bits-1]);
      end
      flags_d[3] = res[bits-1];
      flags_d[2] = (res == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) flags_q <= 4'b0000;
      else     flags_q <= flags_d;
   end

   assign Result = res;
   assign Flags  = flags_d;
   assign FlagsQ = flags_q;

endmodule

// File: tb/tb_asip_alu.sv
// Directed-vector bench for asip_alu (bits=4).
// Checks Result/Flags, the status register and the carry chain.
module tb_asip_alu;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] A, B, C, Control;
   logic [3:0] Result, Flags, FlagsQ;

   int n_vec = 0;
   int n_err = 0;

   asip_alu #(.bits(4)) dut (
      .clk(clk), .rst(rst), .A(A), .B(B), .C(C),
      .Control(Control), .Result(Result),
      .Flags(Flags), .FlagsQ(FlagsQ)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // {ctl, a, b, result, nzcv}
   logic [19:0] vec [$] = '{
      20'h41EF8, 20'h40004, 20'h41F06, 20'h44599,
      20'h22112, 20'h20D30, 20'h27252, 20'h24222,
      20'h321F8,
      20'h04204, 20'h06220,
      20'hC1EF8, 20'hC95D8,
      20'h195C8, 20'h13304,
      20'hF01E8, 20'hF0788,
      20'hEF5A8, 20'hD0660,
      20'hA3306, 20'hB7189, 20'h9AA04
   };

   initial begin
      rst = 1'b1; A = '0; B = '0; C = '0; Control = '0;
      #2;
      chk("rst_flagsq", {4'h0, FlagsQ}, 8'h00);

      @(negedge clk);
      rst = 1'b0; Control = 4'b0100; A = 4'h1; B = 4'hF;
      @(posedge clk);
      #1;
      chk("flagsq_load", {4'h0, FlagsQ}, 8'h06);

      Control = 4'b0101; A = 4'h1; B = 4'h1; C = 4'h0;
      #1;
      chk("adc_cin1", {Result, Flags}, 8'h30);
      C = 4'h1;
      #1;
      chk("adc_cinv", {Result, Flags}, 8'h20);

      rst = 1'b1;
      #1;
      chk("rst_async", {4'h0, FlagsQ}, 8'h00);
      C = 4'h0;
      #1;
      chk("adc_after_rst", {Result, Flags}, 8'h20);
      @(negedge clk);
      rst = 1'b0;

      foreach (vec[i]) begin
         Control = vec[i][19:16];
         A       = vec[i][15:12];
         B       = vec[i][11:8];
         C       = 4'h0;
         #1;
         chk($sformatf("vec%0d_op%h", i, vec[i][19:16]),
             {Result, Flags}, vec[i][7:0]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/asip_alu.md
Name: asip_alu

Overview:
- Parameterised combinational ALU for the ASIP datapath; executes the 16 data-processing operations selected by a 4-bit `Control` code.
- Produces a `bits`-wide `Result` and four condition flags, NZCV.
- A clocked status register holds the last flags; it supplies carry-in for the carry-using operations.

Parameters:
- bits, 4, datapath width of A, B, C and Result (minimum 2).

Ports:
- clk  input  1  system clock; the status register updates on its rising edge.
- rst  input  1  asynchronous active-high reset; clears the status register.
- A  input  bits  first operand.
- B  input  bits  second operand; the sole operand for MOV and MVN.
- C  input  bits  auxiliary operand; C[0] is the carry-in used by ADC/SBC/RSC when the carry-select rule below applies; C[bits-1:1] ignored.
- Control  input  4  operation select.
- Result  output  bits  operation result, combinational.
- Flags  output  4  combinational flags: [3]=N, [2]=Z, [1]=C (carry), [0]=V.
- FlagsQ  output  4  registered copy of Flags (status register).

Behaviour:
- Result and Flags are purely combinational from A, B, C, Control and FlagsQ[1]; zero clock latency. They are not affected by rst except through FlagsQ.
- Carry-in cin for ADC/SBC/RSC is FlagsQ[1] XOR C[0].
  - C[0]=0 uses the stored carry.
  - C[0]=1 uses the inverted stored carry.
- Control decode (two's-complement arithmetic):
  - 0000 AND: A&B.
  - 0001 XOR: A^B.
  - 0010 SUB: A-B.
  - 0011 RSB: B-A.
  - 0100 ADD: A+B.
  - 0101 ADC: A+B+cin.
  - 0110 SBC: A-B-1+cin.
  - 0111 RSC: B-A-1+cin.
  - 1000 TST: A&B.
  - 1001 TEQ: A^B.
  - 1010 CMP: A-B.
  - 1011 CMN: A+B.
  - 1100 OR: A|B.
  - 1101 MOV: B.
  - 1110 BIC: A&~B.
  - 1111 NOT: ~B.
- Compare/test codes 1000-1011 drive the computed value on Result; write-back suppression is the register file's job.
- Arithmetic is computed at bits+1 width.
  - Subtraction is computed as X + ~Y + 1 (or + cin for the carry variants).
- Flags:
  - N = Result[bits-1].
  - Z = (Result == 0).
  - Arithmetic ops (0010-0111, 1010, 1011):
    - C = carry-out bit [bits] of the widened sum.
    - For subtraction C is NOT borrow: A-B with A>=B unsigned gives C=1.
    - V = signed overflow: operands entering the adder have the same sign and the sum sign differs.
  - Logical/move ops (0000, 0001, 1000, 1001, 1100-1111): C=0, V=0.
- Status register:
  - FlagsQ <= Flags on every rising clk.
  - rst=1 forces FlagsQ=4'b0000 immediately and holds it while asserted; no enable.
  - After rst deasserts, the first rising edge loads Flags.
- Boundary cases:
  - Wrap-around: 0001+1111 gives Result=0000, Z=1, C=1.
  - All-zero operands give Z=1, N=0.
  - Unknown/X control is not required to be handled.
- Implementation: single always_comb case plus one always_ff; no latches, full default assignment.

Test Plan:
- ADD bits=4:
  - A=0001, B=1110 -> Result=1111, N=1, Z=0, C=0, V=0.
  - A=0000, B=0000 -> Result=0000, Z=1, N=0, V=0.
  - A=0001, B=1111 -> Result=0000, Z=1, N=0, C=1, V=0.
  - A=0100, B=0101 -> Result=1001, N=1, Z=0, C=0, V=1.
- SUB:
  - 0010-0001 -> 0001, C=1.
  - 0000-1101 -> 0011, C=0.
  - 0111-0010 -> 0101.
  - 0100-0010 -> 0010.
  - RSB A=0010, B=0001 -> 1111, N=1.
- Logic:
  - AND 0100&0010 -> 0000, Z=1; AND 0110&0010 -> 0010.
  - OR 0001|1110 -> 1111; OR 1001|0101 -> 1101.
  - XOR 1001^0101 -> 1100; XOR 0011^0011 -> 0000, Z=1.
  - NOT B=0001 -> 1110; NOT B=0111 -> 1000.
  - BIC A=1111, B=0101 -> 1010.
  - MOV B=0110 -> 0110.
- Status register and carry chain:
  - rst=1 -> FlagsQ=0000 without a clock edge.
  - Release rst, ADD 0001+1111, clock -> FlagsQ=0110.
  - ADC A=0001, B=0001, C=0 -> Result=0011.
  - C[0]=1 -> Result=0010.
- Reset mid-operation: assert rst between edges with FlagsQ nonzero -> FlagsQ=0000 immediately; ADC 0001+0001, C=0 -> 0010.
- Compare ops:
  - CMP A=0011, B=0011 -> Z=1, C=1.
  - CMN A=0111, B=0001 -> Result=1000, V=1.
  - TEQ A=1010, B=1010 -> Z=1, C=0, V=0.
